// File: rtl/result_uart_tx_pkg.sv
// Shared constants and UART FSM encodings for the result UART transmitter.
package result_uart_tx_pkg;

  localparam int DATA_BUS_WIDTH = 24;
  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } uart_state_t;

  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/result_uart_tx_fifo.sv
// result_fifo: word FIFO with combinational read port; pointers wrap modulo DEPTH.
module result_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // DEPTH is a power of two, so pointer wrap is the natural binary overflow.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/result_uart_tx.sv
// result_uart_tx: buffers result words and serialises them MS byte first as UART frames.
// Define RESULT_TX_PARITY_EN for 8E1 frames (11 bits); default build sends 8N1 (10 bits).
module result_uart_tx
  import result_uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_BUS_WIDTH,
  parameter int FIFO_DEPTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [DATA_WIDTH-1:0]         in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          tx,
  output logic                          busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output uart_state_t                   fsm_state
);

  localparam int NUM_BYTES = DATA_WIDTH / UART_DATA_BITS;
  localparam int BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam int BYTE_W    = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NUM_BYTES - 1);

  uart_state_t           state_q, state_d;
  logic [BAUD_W-1:0]     baud_q, baud_d;
  logic [2:0]            bit_q, bit_d;
  logic [BYTE_W-1:0]     byte_q, byte_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic                  tx_q, tx_d;
  logic                  overflow_q;

  logic                  push;
  logic                  pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic [7:0]            cur_byte;
  logic                  baud_done;

  // Handshake: a word transfers on a rising edge where in_valid && in_ready.
  // in_ready depends only on reset and FIFO fullness, never on in_valid or on a
  // same-cycle pop; a valid word offered while !in_ready is dropped and flagged.
  assign in_ready = !reset && !fifo_full;
  assign push     = in_valid && in_ready;

  result_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (in_data),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign cur_byte  = shreg_q[DATA_WIDTH-1 -: 8];
  assign baud_done = (baud_q == BAUD_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      byte_q     <= '0;
      shreg_q    <= '0;
      tx_q       <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      if (in_valid && !in_ready) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // tx_d is the line level for the current state; registering it gives the
  // one-cycle lag between entering START and the falling edge on tx.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    shreg_d = shreg_q;
    tx_d    = 1'b1;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shreg_d = fifo_rdata;
          byte_d  = '0;
          bit_d   = '0;
          baud_d  = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        tx_d = 1'b0;
        if (baud_done) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_DATA: begin
        tx_d = cur_byte[bit_q];
        if (baud_done) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
`ifdef RESULT_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_PARITY: begin
        tx_d = even_parity(cur_byte);
        if (baud_done) begin
          baud_d  = '0;
          state_d = S_STOP;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_STOP: begin
        tx_d = 1'b1;
        if (baud_done) begin
          baud_d = '0;
          if (byte_q != BYTE_LAST) begin
            byte_d  = byte_q + 1'b1;
            shreg_d = shreg_q << 8;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign tx        = tx_q;
  assign overflow  = overflow_q;
  assign busy      = (state_q != S_IDLE) || (fifo_count != '0);
  assign fsm_state = state_q;

endmodule

// File: tb/tb_result_uart_tx.sv
// Self-checking bench for result_uart_tx: directed steps plus random words, decoded by a UART receiver model.
module tb_result_uart_tx;
  import result_uart_tx_pkg::*;

  localparam int CPB   = 4;
  localparam int DEPTH = 8;
  localparam int BYTES = 3;
`ifdef RESULT_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CLKS = FRAME_BITS * CPB;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [23:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        tx;
  logic        busy;
  logic        overflow;
  logic [3:0]  fifo_count;
  uart_state_t fsm_state;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic [7:0] exp_q[$];

  result_uart_tx #(
    .DATA_WIDTH   (24),
    .FIFO_DEPTH   (DEPTH),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .tx         (tx),
    .busy       (busy),
    .overflow   (overflow),
    .fifo_count (fifo_count),
    .fsm_state  (fsm_state)
  );

  // clock/reset block
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void enqueue(input logic [23:0] w);
    for (int b = BYTES - 1; b >= 0; b--) exp_q.push_back(w[8*b +: 8]);
  endfunction

  // Returns at the falling edge that follows rising edge number e.
  task automatic at_edge(input int e);
    do @(negedge clock); while (cyc < e);
  endtask

  // driver tasks
  task automatic push_word(input logic [23:0] w);
    int n;
    n = 0;
    @(negedge clock);
    while (!in_ready && n < 2000) begin
      @(negedge clock);
      n++;
    end
    check("push_ready", 32'(in_ready), 32'd1);
    if (in_ready) enqueue(w);
    in_valid = 1'b1;
    in_data  = w;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    @(negedge clock);
    while (busy !== 1'b0 && n < bound) begin
      @(negedge clock);
      n++;
    end
    check("idle_within_bound", 32'(n < bound), 32'd1);
    repeat (8) @(negedge clock);
  endtask

  // scoreboard: UART receiver sampling mid-bit, compared against exp_q
  initial begin : monitor
    logic [10:0] f;
    logic [7:0]  b;
    bit          ab;
    int          pending;
    forever begin
      @(negedge clock);
      if (!reset && tx === 1'b0) begin
        f  = '0;
        ab = 1'b0;
        for (int c = 1; c <= CPB * (FRAME_BITS - 1) + 2; c++) begin
          @(negedge clock);
          if (reset) begin
            ab = 1'b1;
            break;
          end
          if (c % CPB == 2) f[c / CPB] = tx;
        end
        if (!ab) begin
          b = f[8:1];
          check("start_bit", 32'(f[0]), 32'd0);
          check("stop_bit", 32'(f[FRAME_BITS-1]), 32'd1);
`ifdef RESULT_TX_PARITY_EN
          check("parity_bit", 32'(f[9]), 32'(^b));
`endif
          pending = exp_q.size();
          check("rx_byte_expected", 32'(pending != 0), 32'd1);
          if (pending != 0) check("rx_byte", 32'(b), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin : stimulus
    int t0;
    logic [7:0]            a5;
    logic [FRAME_BITS-1:0] stream;
    logic [23:0]           w;

    // 1. reset held 3 cycles
    repeat (3) @(negedge clock);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_fifo_count", 32'(fifo_count), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_state", 32'(fsm_state), 32'(S_IDLE));
    reset = 1'b0;
    #1;
    check("ready_after_reset", 32'(in_ready), 32'd1);

    // 2. single word: latency, bit stream, frame spacing, busy timing
    push_word(24'hA5C301);
    t0 = cyc;
    a5 = 8'hA5;
    stream = '0;
    stream[8:1] = a5;
`ifdef RESULT_TX_PARITY_EN
    stream[9] = ^a5;
`endif
    stream[FRAME_BITS-1] = 1'b1;
    at_edge(t0 + 1);
    check("tx_high_1_after_push", 32'(tx), 32'd1);
    check("popped_1_after_push", 32'(fifo_count), 32'd0);
    at_edge(t0 + 2);
    check("tx_low_2_after_push", 32'(tx), 32'd0);
    for (int i = 1; i < FRAME_BITS; i++) begin
      at_edge(t0 + 2 + CPB * i + 1);
      check("a5_stream_bit", 32'(tx), 32'(stream[i]));
    end
    at_edge(t0 + 1 + FRAME_CLKS);
    check("last_stop_cycle", 32'(tx), 32'd1);
    at_edge(t0 + 2 + FRAME_CLKS);
    check("second_start", 32'(tx), 32'd0);
    at_edge(t0 + BYTES * FRAME_CLKS);
    check("busy_before_end", 32'(busy), 32'd1);
    at_edge(t0 + BYTES * FRAME_CLKS + 2);
    check("busy_cleared", 32'(busy), 32'd0);
    wait_idle(500);

    // 4. parity word (parity verified by the receiver in the parity build)
    push_word(24'h030001);
    wait_idle(500);

    // 3. ten words with in_valid held high: nine accepted, tenth dropped
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      w = 24'($urandom);
      in_valid = 1'b1;
      in_data  = w;
      check("burst_in_ready", 32'(in_ready), 32'(i < 9));
      if (i == 9) check("overflow_before_drop", 32'(overflow), 32'd0);
      if (i < 9) enqueue(w);
      @(posedge clock);
    end
    #1;
    in_valid = 1'b0;
    check("overflow_set", 32'(overflow), 32'd1);
    wait_idle(3000);
    check("overflow_sticky", 32'(overflow), 32'd1);
    check("burst_drained", 32'(exp_q.size()), 32'd0);

    // 5. reset during DATA of byte 2
    push_word(24'h123456);
    t0 = cyc;
    push_word(24'h789ABC);
    at_edge(t0 + 1 + FRAME_CLKS + CPB + 10);
    check("pre_reset_count", 32'(fifo_count), 32'd1);
    check("pre_reset_overflow", 32'(overflow), 32'd1);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("midframe_reset_tx", 32'(tx), 32'd1);
    check("midframe_reset_count", 32'(fifo_count), 32'd0);
    check("midframe_reset_overflow", 32'(overflow), 32'd0);
    check("midframe_reset_busy", 32'(busy), 32'd0);
    exp_q.delete();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    push_word(24'h5A0FF0);
    wait_idle(500);
    check("post_reset_frame_drained", 32'(exp_q.size()), 32'd0);

    // 6. simultaneous push and pop at count 3, then wrap the pointers
    push_word(24'($urandom));
    t0 = cyc;
    for (int i = 0; i < 3; i++) push_word(24'($urandom));
    at_edge(t0 + BYTES * FRAME_CLKS + 1);
    check("count_before_pushpop", 32'(fifo_count), 32'd3);
    check("busy_with_queue", 32'(busy), 32'd1);
    w = 24'($urandom);
    in_valid = 1'b1;
    in_data  = w;
    check("pushpop_ready", 32'(in_ready), 32'd1);
    enqueue(w);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    at_edge(t0 + BYTES * FRAME_CLKS + 2);
    check("count_after_pushpop", 32'(fifo_count), 32'd3);
    for (int i = 0; i < 4; i++) push_word(24'($urandom));
    check("count_after_wrap_pushes", 32'(fifo_count), 32'd7);
    wait_idle(3000);

    // random words with random gaps
    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(0, 30)) @(negedge clock);
      push_word(24'($urandom));
    end
    wait_idle(4000);

    // final report
    check("all_bytes_received", 32'(exp_q.size()), 32'd0);
    check("final_tx_idle", 32'(tx), 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
